// File: rtl/alu_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_acc_ctrl
// Brief   : Registered accumulator control stage around a 4-bit add/sub/or/and
//           ALU with valid/ready command and result handshakes.
// Revision: 1.0
// ============================================================================
module alu_acc_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_s,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_b;
  logic             r_load;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_zero;
  logic             r_res_valid;
  logic [CNT_W-1:0] r_op_count;

  logic [WIDTH-1:0] w_result;
  logic             w_cmd_fire;

  // A load bypasses the ALU so the accumulator can be seeded without a prior clear.
  assign w_result   = r_load ? r_b : alu_out;
  assign w_cmd_fire = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= 2'b00;
      r_b         <= '0;
      r_load      <= 1'b0;
      r_acc       <= '0;
      r_res_data  <= '0;
      r_res_zero  <= 1'b0;
      r_res_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_op    <= cmd_op;
            r_b     <= cmd_b;
            r_load  <= cmd_load;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_acc       <= w_result;
          r_res_data  <= w_result;
          r_res_zero  <= (w_result == '0);
          r_res_valid <= 1'b1;
          r_op_count  <= r_op_count + 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst so no command is acknowledged in a cycle that will be reset.
  assign cmd_ready = (r_state == IDLE) && !rst;

  assign alu_s     = r_op;
  assign alu_a     = r_acc;
  assign alu_b     = r_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_zero  = r_res_zero;
  assign acc       = r_acc;
  assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_acc_ctrl
// Brief   : Directed self-checking bench for alu_acc_ctrl with an ALU model.
// Revision: 1.0
// ============================================================================
module tb_alu_acc_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       alu_s;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Combinational 4-bit ALU in the loop
  always_comb begin
    alu_out = '0;
    case (alu_s)
      2'b00: alu_out = alu_a + alu_b;
      2'b01: alu_out = alu_a - alu_b;
      2'b10: alu_out = alu_a | alu_b;
      2'b11: alu_out = alu_a & alu_b;
      default: alu_out = '0;
    endcase
  end

  alu_acc_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_load  (cmd_load),
    .cmd_b     (cmd_b),
    .alu_s     (alu_s),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .acc       (acc),
    .op_count  (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return #1 after the edge that accepts it.
  task automatic issue(input logic [1:0] op, input logic ld, input logic [WIDTH-1:0] b);
    int waited;
    cmd_op    = op;
    cmd_load  = ld;
    cmd_b     = b;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Full operation: accept, check EXEC and DONE cycles, then drain the result.
  task automatic run(input string tag, input logic [1:0] op, input logic ld,
                     input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp,
                     input logic exp_zero);
    issue(op, ld, b);
    chk({tag, "_exec_valid"}, 32'(res_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_data"},  32'(res_data),  32'(exp));
    chk({tag, "_zero"},  32'(res_zero),  32'(exp_zero));
    chk({tag, "_acc"},   32'(acc),       32'(exp));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_drained"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_load  = 1'b1;
    cmd_b     = 4'd5;
    res_ready = 1'b0;

    // Reset held two cycles with a command offered
    step();
    chk("rst_cmd_ready_1", 32'(cmd_ready), 32'd0);
    step();
    chk("rst_cmd_ready_2", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    rst       = 1'b0;
    #1;
    chk("rst_acc",       32'(acc),       32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_op_count",  32'(op_count),  32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_alu_s",     32'(alu_s),     32'd0);
    chk("rst_alu_b",     32'(alu_b),     32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Load 7, then add 4 with EXEC-cycle ALU drive checks
    run("load7", 2'b00, 1'b1, 4'd7, 4'd7, 1'b0);
    issue(2'b00, 1'b0, 4'd4);
    chk("add_alu_s", 32'(alu_s), 32'd0);
    chk("add_alu_a", 32'(alu_a), 32'd7);
    chk("add_alu_b", 32'(alu_b), 32'd4);
    chk("add_exec_valid", 32'(res_valid), 32'd0);
    step();
    chk("add_valid", 32'(res_valid), 32'd1);
    chk("add_data",  32'(res_data),  32'd11);
    chk("add_zero",  32'(res_zero),  32'd0);
    chk("add_count", 32'(op_count),  32'd2);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Sub to zero, then wrap-around add
    run("sub11", 2'b01, 1'b0, 4'd11, 4'd0,  1'b1);
    run("load15", 2'b00, 1'b1, 4'd15, 4'd15, 1'b0);
    run("add_wrap", 2'b00, 1'b0, 4'd1, 4'd0, 1'b1);

    // Logic ops
    run("load10", 2'b00, 1'b1, 4'b1010, 4'b1010, 1'b0);
    run("or5",    2'b10, 1'b0, 4'b0101, 4'b1111, 1'b0);
    run("and3",   2'b11, 1'b0, 4'b0011, 4'b0011, 1'b0);
    chk("logic_count", 32'(op_count), 32'd8);

    // Backpressure: 3 + 2 = 5 held in DONE while a new sub 1 waits
    issue(2'b00, 1'b0, 4'd2);
    step();
    cmd_op    = 2'b01;
    cmd_load  = 1'b0;
    cmd_b     = 4'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",     32'(res_valid), 32'd1);
      chk("bp_data",      32'(res_data),  32'd5);
      chk("bp_acc",       32'(acc),       32'd5);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    chk("bp_alu_b_held", 32'(alu_b), 32'd2);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
    chk("bp_idle_valid", 32'(res_valid), 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("bp_new_alu_s", 32'(alu_s), 32'd1);
    chk("bp_new_alu_b", 32'(alu_b), 32'd1);
    step();
    chk("bp_new_data",  32'(res_data), 32'd4);
    chk("bp_new_count", 32'(op_count), 32'd10);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset during EXEC discards the load of 9
    issue(2'b00, 1'b1, 4'd9);
    rst = 1'b1;
    step();
    chk("rexec_acc",       32'(acc),       32'd0);
    chk("rexec_valid",     32'(res_valid), 32'd0);
    chk("rexec_count",     32'(op_count),  32'd0);
    chk("rexec_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rexec_after_valid", 32'(res_valid), 32'd0);
      chk("rexec_after_acc",   32'(acc),       32'd0);
    end
    chk("rexec_ready", 32'(cmd_ready), 32'd1);

    // 256 completed operations wrap the counter
    res_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      issue(2'b00, 1'b1, 4'(i));
      step();
      step();
    end
    chk("count_255", 32'(op_count), 32'd255);
    issue(2'b00, 1'b0, 4'd1);
    step();
    chk("count_wrap", 32'(op_count), 32'd0);
    chk("wrap_data",  32'(res_data), 32'd15);
    step();
    res_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
